// File: rtl/bzmusic_pkg.sv
// rtl/bzmusic_pkg.sv - tune codes, note frequencies and period lookup for the buzzer tone generator
package bzmusic_pkg;

    localparam int NOTE_C_HZ = 262;
    localparam int NOTE_D_HZ = 294;
    localparam int NOTE_E_HZ = 330;
    localparam int NOTE_F_HZ = 349;
    localparam int NOTE_G_HZ = 392;
    localparam int NOTE_A_HZ = 440;
    localparam int NOTE_B_HZ = 494;

    localparam logic [4:0] TUNE_REST = 5'd0;
    localparam logic [4:0] TUNE_C4 = 5'd1,  TUNE_D4 = 5'd2,  TUNE_E4 = 5'd3,  TUNE_F4 = 5'd4;
    localparam logic [4:0] TUNE_G4 = 5'd5,  TUNE_A4 = 5'd6,  TUNE_B4 = 5'd7;
    localparam logic [4:0] TUNE_C5 = 5'd8,  TUNE_D5 = 5'd9,  TUNE_E5 = 5'd10, TUNE_F5 = 5'd11;
    localparam logic [4:0] TUNE_G5 = 5'd12, TUNE_A5 = 5'd13, TUNE_B5 = 5'd14;
    localparam logic [4:0] TUNE_C6 = 5'd15, TUNE_D6 = 5'd16, TUNE_E6 = 5'd17, TUNE_F6 = 5'd18;
    localparam logic [4:0] TUNE_G6 = 5'd19, TUNE_A6 = 5'd20, TUNE_B6 = 5'd21;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_note(input logic [4:0] code);
        return (code >= TUNE_C4) && (code <= TUNE_B6);
    endfunction

    function automatic int base_freq(input int idx);
        case (idx)
            0:       return NOTE_C_HZ;
            1:       return NOTE_D_HZ;
            2:       return NOTE_E_HZ;
            3:       return NOTE_F_HZ;
            4:       return NOTE_G_HZ;
            5:       return NOTE_A_HZ;
            default: return NOTE_B_HZ;
        endcase
    endfunction

    // Codes step through seven notes per octave; each octave doubles the base frequency.
    function automatic logic [31:0] tune_period(input logic [4:0] code, input int clk_hz);
        int idx;
        int oct;
        int freq;
        if (!is_note(code)) begin
            return 32'(clk_hz / 1000);
        end
        idx  = (int'(code) - 1) % 7;
        oct  = (int'(code) - 1) / 7;
        freq = base_freq(idx) << oct;
        return 32'(clk_hz / freq);
    endfunction

endpackage

// File: rtl/bzmusic_period_rom.sv
// rtl/bzmusic_period_rom.sv - constant tune code to period table
module bzmusic_period_rom
    import bzmusic_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 18
) (
    input  logic [4:0]       code_i,
    output logic [DIV_W-1:0] period_o
);

    logic [DIV_W-1:0] period_tbl [32];

    // Every entry folds to a constant at elaboration, so no divider is built.
    for (genvar i = 0; i < 32; i++) begin : g_tbl
        localparam logic [DIV_W-1:0] PERIOD = DIV_W'(tune_period(5'(i), CLK_HZ));
        assign period_tbl[i] = PERIOD;
    end

    assign period_o = period_tbl[code_i];

endmodule

// File: rtl/bzmusic_tune_pwm.sv
// rtl/bzmusic_tune_pwm.sv - glitch-free square-wave buzzer tone generator with volume select
module bzmusic_tune_pwm
    import bzmusic_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 18
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tune_pwm_en,
    input  logic       tune_pwm_rstn,
    input  logic [4:0] tune_code,
    input  logic [1:0] vol,
    output logic       pwm_out,
    output logic       tone_active,
    output logic       period_done
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic [DIV_W-1:0] h_q, h_d;
    logic [4:0]       code_q, code_d;
    logic [1:0]       vol_q, vol_d;
    logic             pwm_q, pwm_d;
    logic [DIV_W-1:0] rom_p;
    logic [DIV_W-1:0] rom_h;
    logic             run_ok;
    logic             at_end;
    logic             latch_en;

    bzmusic_period_rom #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_rom (
        .code_i   (tune_code),
        .period_o (rom_p)
    );

    assign rom_h  = rom_p >> ({1'b0, vol} + 3'd1);
    assign run_ok = tune_pwm_en && tune_pwm_rstn;
    assign at_end = (state_q == ST_RUN) && (cnt_q == p_q - DIV_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        h_d      = h_q;
        code_d   = code_q;
        vol_d    = vol_q;
        pwm_d    = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (run_ok) begin
                    state_d  = ST_RUN;
                    latch_en = 1'b1;
                end
            end
            ST_RUN: begin
                // Disable beats a coinciding boundary: drop to idle without re-latching.
                if (!run_ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    code_d  = TUNE_REST;
                end else begin
                    pwm_d = (cnt_q < h_q) && is_note(code_q);
                    if (at_end) begin
                        cnt_d    = '0;
                        latch_en = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (latch_en) begin
            code_d = tune_code;
            vol_d  = vol;
            p_d    = rom_p;
            h_d    = rom_h;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            h_q     <= '0;
            code_q  <= TUNE_REST;
            vol_q   <= 2'd0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            h_q     <= h_d;
            code_q  <= code_d;
            vol_q   <= vol_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign tone_active = (state_q == ST_RUN) && is_note(code_q);
    assign period_done = at_end;

endmodule
